// File: rtl/otp_fuse_emu.sv
// Behavioural eFuse/OTP macro emulator: a byte-wide fuse array behind the
// csb/strobe/load/pgenb/vddqsw pin protocol, with sticky protocol-violation flags.
module otp_fuse_emu #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned TRD_MIN  = 2,
    parameter int unsigned TPGM_MIN = 8,
    parameter int unsigned TPGM_MAX = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              i_otp_csb,
    input  logic              i_otp_vddqsw,
    input  logic              i_otp_pgenb,
    input  logic              i_otp_load,
    input  logic              i_otp_strobe,
    input  logic [ADDR_W+2:0] i_otp_addr,
    output logic [7:0]        o_otp_q,
    input  logic              i_fuse_wipe,
    input  logic              i_err_clr,
    output logic              o_err_mode,
    output logic              o_err_short,
    output logic              o_err_long,
    output logic              o_err_addr,
    output logic [ADDR_W+3:0] o_pgm_cnt,
    output logic              o_busy
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned AW     = ADDR_W + 3;
    localparam int unsigned PCNT_W = ADDR_W + 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_PG   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]       lat_q, lat_d;
    logic [7:0]          q_q, q_d;
    logic                err_mode_q, err_short_q, err_long_q, err_addr_q;
    logic                busy_q;
    logic [PCNT_W-1:0]   pgm_cnt_q;
    logic [7:0]          mem_q [DEPTH];

    logic                csb_q, vddqsw_q, pgenb_q, load_q, strobe_q, strobe_prev_q;
    logic [AW-1:0]       addr_q;

    logic                rise_c, rd_mode_c, pg_mode_c, mode_ok_c;
    logic                set_mode_c, set_short_c, set_long_c, set_addr_c, wr_en_c;
    logic [ADDR_W-1:0]   byte_c;
    logic [2:0]          bit_c;
    logic                bit_was_set_c;

    // Pin samplers are deliberately not reset so a strobe held across rst_n
    // does not look like a fresh rising edge afterwards.
    always_ff @(posedge sys_clk) begin
        csb_q         <= i_otp_csb;
        vddqsw_q      <= i_otp_vddqsw;
        pgenb_q       <= i_otp_pgenb;
        load_q        <= i_otp_load;
        strobe_q      <= i_otp_strobe;
        strobe_prev_q <= strobe_q;
        addr_q        <= i_otp_addr;
    end

    assign rise_c        = strobe_q & ~strobe_prev_q;
    assign rd_mode_c     = pgenb_q & load_q & ~vddqsw_q;
    assign pg_mode_c     = ~pgenb_q & ~load_q & vddqsw_q;
    assign mode_ok_c     = (state_q == ST_RD) ? rd_mode_c : pg_mode_c;
    assign byte_c        = lat_q[AW-1:3];
    assign bit_c         = lat_q[2:0];
    assign bit_was_set_c = mem_q[byte_c][bit_c];

    // State register and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lat_q       <= '0;
            q_q         <= 8'h00;
            err_mode_q  <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_addr_q  <= 1'b0;
            busy_q      <= 1'b0;
            pgm_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            q_q         <= q_d;
            err_mode_q  <= set_mode_c  | (err_mode_q  & ~i_err_clr);
            err_short_q <= set_short_c | (err_short_q & ~i_err_clr);
            err_long_q  <= set_long_c  | (err_long_q  & ~i_err_clr);
            err_addr_q  <= set_addr_c  | (err_addr_q  & ~i_err_clr);
            busy_q      <= (state_d != ST_IDLE);
            if (i_fuse_wipe) begin
                pgm_cnt_q <= '0;
            end else if (wr_en_c && !bit_was_set_c && (pgm_cnt_q != '1)) begin
                pgm_cnt_q <= pgm_cnt_q + PCNT_W'(1);
            end
        end
    end

    // Fuse array survives rst_n; wipe beats a same-cycle program write.
    always_ff @(posedge sys_clk) begin
        if (i_fuse_wipe) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[ADDR_W'(i)] <= 8'h00;
            end
        end else if (wr_en_c && rst_n) begin
            mem_q[byte_c][bit_c] <= 1'b1;
        end
    end

    // Next-state, pulse counting and violation detection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        q_d         = q_q;
        set_mode_c  = 1'b0;
        set_short_c = 1'b0;
        set_long_c  = 1'b0;
        set_addr_c  = 1'b0;
        wr_en_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise_c && !csb_q) begin
                    if (rd_mode_c) begin
                        state_d = ST_RD;
                        lat_d   = addr_q;
                        cnt_d   = CNT_W'(1);
                    end else if (pg_mode_c) begin
                        state_d = ST_PG;
                        lat_d   = addr_q;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        set_mode_c = 1'b1;
                    end
                end
            end
            ST_RD, ST_PG: begin
                if (strobe_q) begin
                    if (addr_q != lat_q) begin
                        set_addr_c = 1'b1;
                        state_d    = ST_IDLE;
                    end else if (csb_q || !mode_ok_c) begin
                        set_mode_c = 1'b1;
                        state_d    = ST_IDLE;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_IDLE;
                    if (state_q == ST_RD) begin
                        if (cnt_q >= CNT_W'(TRD_MIN)) begin
                            q_d = mem_q[byte_c];
                        end else begin
                            set_short_c = 1'b1;
                        end
                    end else if (cnt_q < CNT_W'(TPGM_MIN)) begin
                        set_short_c = 1'b1;
                    end else begin
                        wr_en_c    = 1'b1;
                        set_long_c = (cnt_q > CNT_W'(TPGM_MAX));
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_otp_q     = q_q;
    assign o_err_mode  = err_mode_q;
    assign o_err_short = err_short_q;
    assign o_err_long  = err_long_q;
    assign o_err_addr  = err_addr_q;
    assign o_pgm_cnt   = pgm_cnt_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_otp_fuse_emu.sv
// Directed bench for otp_fuse_emu: read/program pulses, width limits, aborts,
// reset mid-program and wipe, checked against hand-computed values.
module tb_otp_fuse_emu;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       i_otp_csb, i_otp_vddqsw, i_otp_pgenb, i_otp_load, i_otp_strobe;
    logic [7:0] i_otp_addr;
    logic [7:0] o_otp_q;
    logic       i_fuse_wipe, i_err_clr;
    logic       o_err_mode, o_err_short, o_err_long, o_err_addr;
    logic [8:0] o_pgm_cnt;
    logic       o_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 sys_clk = ~sys_clk;

    otp_fuse_emu dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .i_otp_csb    (i_otp_csb),
        .i_otp_vddqsw (i_otp_vddqsw),
        .i_otp_pgenb  (i_otp_pgenb),
        .i_otp_load   (i_otp_load),
        .i_otp_strobe (i_otp_strobe),
        .i_otp_addr   (i_otp_addr),
        .o_otp_q      (o_otp_q),
        .i_fuse_wipe  (i_fuse_wipe),
        .i_err_clr    (i_err_clr),
        .o_err_mode   (o_err_mode),
        .o_err_short  (o_err_short),
        .o_err_long   (o_err_long),
        .o_err_addr   (o_err_addr),
        .o_pgm_cnt    (o_pgm_cnt),
        .o_busy       (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pins_idle();
        i_otp_csb    = 1'b1;
        i_otp_pgenb  = 1'b1;
        i_otp_load   = 1'b0;
        i_otp_vddqsw = 1'b0;
        i_otp_strobe = 1'b0;
    endtask

    task automatic pulse_start(input logic prog, input logic [4:0] b, input logic [2:0] bs);
        i_otp_csb    = 1'b0;
        i_otp_pgenb  = ~prog;
        i_otp_load   = ~prog;
        i_otp_vddqsw = prog;
        i_otp_addr   = {b, bs};
        wait_n(1);
        i_otp_strobe = 1'b1;
    endtask

    task automatic pulse_end();
        i_otp_strobe = 1'b0;
        wait_n(3);
        pins_idle();
        wait_n(1);
    endtask

    task automatic op(input logic prog, input logic [4:0] b, input logic [2:0] bs, input int len);
        pulse_start(prog, b, bs);
        wait_n(len);
        pulse_end();
    endtask

    task automatic read_check(input string tag, input logic [4:0] b, input logic [7:0] exp);
        op(1'b0, b, 3'd0, 3);
        check(tag, 32'(o_otp_q), 32'(exp));
    endtask

    task automatic clear_errs();
        i_err_clr = 1'b1;
        wait_n(1);
        i_err_clr = 1'b0;
    endtask

    function automatic logic [31:0] errs();
        return {28'd0, o_err_mode, o_err_short, o_err_long, o_err_addr};
    endfunction

    initial begin
        rst_n       = 1'b0;
        i_fuse_wipe = 1'b1;
        i_err_clr   = 1'b0;
        i_otp_addr  = 8'h00;
        pins_idle();
        wait_n(3);
        i_fuse_wipe = 1'b0;
        rst_n       = 1'b1;
        wait_n(1);
        check("rst_q", 32'(o_otp_q), 32'h00);
        check("rst_errs", errs(), 32'h0);
        check("rst_pgm", 32'(o_pgm_cnt), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);

        // 1: plain read, busy during pulse, minimum and too-short reads
        pulse_start(1'b0, 5'd3, 3'd0);
        wait_n(2);
        check("t1_busy_mid", 32'(o_busy), 32'd1);
        wait_n(1);
        pulse_end();
        check("t1_q", 32'(o_otp_q), 32'h00);
        check("t1_errs", errs(), 32'h0);
        check("t1_busy_after", 32'(o_busy), 32'd0);
        op(1'b0, 5'd3, 3'd0, 2);
        check("t1_rd_min_errs", errs(), 32'h0);
        op(1'b0, 5'd3, 3'd0, 1);
        check("t1_rd_short", errs(), 32'h4);
        clear_errs();

        // 2: program byte 5 bit 2, then boundary widths 8 and 16 on byte 12
        op(1'b1, 5'd5, 3'd2, 10);
        check("t2_pgm1", 32'(o_pgm_cnt), 32'd1);
        read_check("t2_q5", 5'd5, 8'h04);
        check("t2_errs", errs(), 32'h0);
        op(1'b1, 5'd12, 3'd0, 8);
        op(1'b1, 5'd12, 3'd1, 16);
        read_check("t2_q12", 5'd12, 8'h03);
        check("t2_errs_edge", errs(), 32'h0);
        check("t2_pgm3", 32'(o_pgm_cnt), 32'd3);

        // 3: short program does not write; long program writes and flags
        op(1'b1, 5'd5, 3'd0, 4);
        check("t3_short", errs(), 32'h4);
        read_check("t3_q5a", 5'd5, 8'h04);
        check("t3_pgm_a", 32'(o_pgm_cnt), 32'd3);
        op(1'b1, 5'd5, 3'd7, 20);
        check("t3_long", errs(), 32'h6);
        read_check("t3_q5b", 5'd5, 8'h84);
        check("t3_pgm_b", 32'(o_pgm_cnt), 32'd4);

        // 4: re-blow is a no-op for the counter; clear flags
        op(1'b1, 5'd5, 3'd2, 10);
        check("t4_pgm", 32'(o_pgm_cnt), 32'd4);
        clear_errs();
        check("t4_clr", errs(), 32'h0);

        // 5: illegal mode, address change and csb release mid-pulse
        i_otp_csb    = 1'b0;
        i_otp_pgenb  = 1'b0;
        i_otp_load   = 1'b0;
        i_otp_vddqsw = 1'b0;
        i_otp_addr   = {5'd6, 3'd0};
        wait_n(1);
        i_otp_strobe = 1'b1;
        wait_n(10);
        pulse_end();
        check("t5_mode", errs(), 32'h8);
        read_check("t5_q6", 5'd6, 8'h00);
        check("t5_pgm", 32'(o_pgm_cnt), 32'd4);
        clear_errs();
        pulse_start(1'b1, 5'd7, 3'd3);
        wait_n(4);
        i_otp_addr = {5'd8, 3'd3};
        wait_n(6);
        pulse_end();
        check("t5_addr", errs(), 32'h1);
        read_check("t5_q7", 5'd7, 8'h00);
        read_check("t5_q8", 5'd8, 8'h00);
        clear_errs();
        pulse_start(1'b1, 5'd10, 3'd4);
        wait_n(4);
        i_otp_csb = 1'b1;
        wait_n(6);
        pulse_end();
        check("t5_csb", errs(), 32'h8);
        read_check("t5_q10", 5'd10, 8'h00);
        check("t5_pgm_end", 32'(o_pgm_cnt), 32'd4);

        // 6: reset mid-program keeps array, then wipe
        pulse_start(1'b1, 5'd9, 3'd1);
        wait_n(5);
        rst_n = 1'b0;
        wait_n(2);
        rst_n = 1'b1;
        wait_n(5);
        pulse_end();
        check("t6_pgm_rst", 32'(o_pgm_cnt), 32'd0);
        check("t6_errs_rst", errs(), 32'h0);
        read_check("t6_q9", 5'd9, 8'h00);
        read_check("t6_q5", 5'd5, 8'h84);
        i_fuse_wipe = 1'b1;
        wait_n(1);
        i_fuse_wipe = 1'b0;
        read_check("t6_q5_wiped", 5'd5, 8'h00);
        read_check("t6_q12_wiped", 5'd12, 8'h00);
        check("t6_pgm_wiped", 32'(o_pgm_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
